// File: rtl/lcd_i2c_pkg.sv
// Shared types and constants for the LCD I2C target.
// State list grows RD_DATA/RD_ACK under LCD_I2C_TARGET_READBACK_EN.
package lcd_i2c_pkg;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h27;
  localparam int MSG_BYTES_DEF = 3;

  localparam logic [23:0] MSG_WAT = 24'h574154;
  localparam logic [23:0] MSG_DON = 24'h444f4e;
  localparam logic [23:0] MSG_IDL = 24'h49444c;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
`ifdef LCD_I2C_TARGET_READBACK_EN
    IGNORE,
    RD_DATA,
    RD_ACK
`else
    IGNORE
`endif
  } state_e;

endpackage

// File: rtl/lcd_i2c_target_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge and
// START/STOP condition pulses on the synchronized lines.
module i2c_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;

  // Synchronize both lines and keep one cycle of history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= scl_i;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= sda_i;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  logic scl_hi;
  assign scl_hi = scl_s2_q & scl_prev_q;

  assign sda_o       = sda_s2_q;
  assign scl_rise_o  = scl_s2_q & ~scl_prev_q;
  assign scl_fall_o  = ~scl_s2_q & scl_prev_q;
  assign start_det_o = scl_hi & sda_prev_q & ~sda_s2_q;
  assign stop_det_o  = scl_hi & ~sda_prev_q & sda_s2_q;

endmodule

// File: rtl/lcd_i2c_target.sv
// Write-only I2C target latching fixed-length LCD messages.
// LCD_I2C_TARGET_READBACK_EN adds read-back of the last message.
module lcd_i2c_target
  import lcd_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEF,
  parameter int         MSG_BYTES = MSG_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   scl_in,
  input  logic                   sda_in,
  output logic                   sda_oe,
  output logic [8*MSG_BYTES-1:0] msg_data,
  output logic                   msg_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int MW = 8 * MSG_BYTES;
  localparam int CW = $clog2(MSG_BYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(MSG_BYTES);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_det_o(start_det),
    .stop_det_o (stop_det)
  );

  state_e          state_q;
  logic [2:0]      bit_cnt_q;
  logic [CW-1:0]   byte_cnt_q;
  logic [6:0]      sh_q;
  logic [7:0]      shadow_q [MSG_BYTES];
  logic            ovf_q, wr_q, busy_q;
  logic            sda_oe_q, msg_valid_q, frame_err_q;
  logic [MW-1:0]   msg_data_q;
`ifdef LCD_I2C_TARGET_READBACK_EN
  localparam logic [CW-1:0] LAST_RD = CW'(MSG_BYTES - 1);
  logic            rd_q;
  logic [MW-1:0]   tx_q;
`endif

  logic [7:0]    nxt_byte;
  logic [MW-1:0] shadow_flat;
  logic          addr_hit;

  assign nxt_byte = {sh_q, sda_s};
  assign addr_hit = nxt_byte[7:1] == DEV_ADDR;

  // Flatten the shadow bytes, first byte in the MSBs.
  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < MSG_BYTES; i++)
      shadow_flat[MW-1-8*i -: 8] = shadow_q[i];
  end

  // Protocol FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      sh_q        <= '0;
      ovf_q       <= 1'b0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      msg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      msg_data_q  <= '0;
      for (int i = 0; i < MSG_BYTES; i++)
        shadow_q[i] <= '0;
`ifdef LCD_I2C_TARGET_READBACK_EN
      rd_q        <= 1'b0;
      tx_q        <= '0;
`endif
    end else begin
      msg_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (start_det || stop_det) begin
        // A repeated START closes a write just like STOP.
        if (wr_q) begin
          if (byte_cnt_q == LAST && !ovf_q) begin
            msg_data_q  <= shadow_flat;
            msg_valid_q <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        wr_q       <= 1'b0;
        busy_q     <= 1'b0;
        ovf_q      <= 1'b0;
        sda_oe_q   <= 1'b0;
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
`ifdef LCD_I2C_TARGET_READBACK_EN
        rd_q       <= 1'b0;
`endif
        state_q    <= start_det ? ADDR : IDLE;
      end else begin
        unique case (state_q)
          ADDR: if (scl_rise) begin
            sh_q      <= nxt_byte[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (addr_hit && !nxt_byte[0]) begin
                state_q <= ADDR_ACK;
                busy_q  <= 1'b1;
                wr_q    <= 1'b1;
`ifdef LCD_I2C_TARGET_READBACK_EN
              end else if (addr_hit) begin
                state_q <= ADDR_ACK;
                busy_q  <= 1'b1;
                rd_q    <= 1'b1;
                tx_q    <= msg_data_q;
`endif
              end else begin
                state_q <= IGNORE;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
`ifdef LCD_I2C_TARGET_READBACK_EN
            end else if (rd_q) begin
              sda_oe_q <= ~tx_q[MW-1];
              state_q  <= RD_DATA;
`endif
            end else begin
              sda_oe_q <= 1'b0;
              state_q  <= WR_DATA;
            end
          end
          WR_DATA: if (scl_rise) begin
            sh_q      <= nxt_byte[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_cnt_q == LAST) begin
                ovf_q   <= 1'b1;
                state_q <= IGNORE;
              end else begin
                for (int i = 0; i < MSG_BYTES; i++)
                  if (byte_cnt_q == CW'(i))
                    shadow_q[i] <= nxt_byte;
                state_q <= WR_ACK;
              end
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              sda_oe_q   <= 1'b0;
              byte_cnt_q <= byte_cnt_q + 1'b1;
              state_q    <= WR_DATA;
            end
          end
`ifdef LCD_I2C_TARGET_READBACK_EN
          RD_DATA: begin
            if (scl_fall)
              sda_oe_q <= ~tx_q[MW-1];
            if (scl_rise) begin
              tx_q      <= tx_q << 1;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7)
                state_q <= RD_ACK;
            end
          end
          RD_ACK: begin
            if (scl_fall)
              sda_oe_q <= 1'b0;
            if (scl_rise) begin
              if (!sda_s && byte_cnt_q != LAST_RD) begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
                state_q    <= RD_DATA;
              end else begin
                state_q <= IGNORE;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign msg_data  = msg_data_q;
  assign msg_valid = msg_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_i2c_target.sv
// Self-checking bench for lcd_i2c_target: directed
// scenarios plus random write transactions vs a message model.
module tb_lcd_i2c_target;

  localparam time T = 50ns;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_drv = 1'b1;
  logic        sda_oe;
  logic [23:0] msg_data;
  logic        msg_valid, frame_err, busy;
  logic        sda_line;

  assign sda_line = sda_drv & ~sda_oe;

  lcd_i2c_target dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl_in   (scl),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .msg_data (msg_data),
    .msg_valid(msg_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5ns clk = ~clk;

  int nval = 0;
  int nfe  = 0;
  int noe  = 0;

  always @(posedge clk) begin
    if (msg_valid) nval++;
    if (frame_err) nfe++;
    if (sda_oe) noe++;
  end

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] exp_msg = 24'h0;
  logic [7:0]  buf_b [8];
  bit          ack_got [$];

  task automatic i2c_start();
    sda_drv = 1'b1; #T;
    scl = 1'b1; #(2*T);
    sda_drv = 1'b0; #(2*T);
    scl = 1'b0; #T;
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; #T;
    scl = 1'b1; #(2*T);
    sda_drv = 1'b1; #(2*T);
  endtask

  task automatic send_bit(input bit b);
    sda_drv = b; #T;
    scl = 1'b1; #(2*T);
    scl = 1'b0; #T;
  endtask

  task automatic get_ack(output bit a);
    sda_drv = 1'b1; #T;
    scl = 1'b1; #T;
    a = ~sda_line; #T;
    scl = 1'b0; #T;
  endtask

  task automatic send_byte(input logic [7:0] v);
    bit a;
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    get_ack(a);
    ack_got.push_back(a);
  endtask

  task automatic recv_byte(output logic [7:0] v, input bit ack);
    v = '0;
    for (int i = 0; i < 8; i++) begin
      sda_drv = 1'b1; #T;
      scl = 1'b1; #T;
      v = {v[6:0], sda_line}; #T;
      scl = 1'b0; #T;
    end
    send_bit(!ack);
  endtask

  task automatic do_write(input logic [7:0] ab, input int n,
                          input bit with_stop);
    ack_got.delete();
    i2c_start();
    send_byte(ab);
    for (int i = 0; i < n; i++) send_byte(buf_b[i]);
    if (with_stop) begin
      i2c_stop();
      repeat (4) @(posedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({sda_oe, msg_valid, frame_err, busy} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_ctl got=%b want=0000",
               {sda_oe, msg_valid, frame_err, busy});
    end
    vectors++;
    if (msg_data !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_msg got=%h want=000000", msg_data);
    end
    #100ns;
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    vectors++;
    if ({sda_oe, msg_valid, frame_err, busy} !== 4'b0 || noe != 0) begin
      miscompares++;
      $display("FAIL idle_outs got=%b oe_cycles=%0d want=0000/0",
               {sda_oe, msg_valid, frame_err, busy}, noe);
    end
  endtask

  task automatic test_reset_mid();
    int v0, f0;
    logic [7:0] ab;
    v0 = nval; f0 = nfe;
    ab = 8'h4E;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(ab[i]);
    vectors++;
    if (sda_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_ack_oe got=%b want=1", sda_oe);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (sda_oe !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_rel oe=%b busy=%b want=0/0",
               sda_oe, busy);
    end
    #100ns;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) send_bit(1'($urandom));
    i2c_stop();
    repeat (4) @(posedge clk);
    vectors++;
    if (nval != v0 || nfe != f0 || msg_data !== exp_msg) begin
      miscompares++;
      $display("FAIL mid_reset_after val=%0d fe=%0d msg=%h want=0/0/%h",
               nval - v0, nfe - f0, msg_data, exp_msg);
    end
  endtask

  task automatic test_write_ok();
    int v0, f0;
    v0 = nval; f0 = nfe;
    buf_b[0] = 8'h57; buf_b[1] = 8'h41; buf_b[2] = 8'h54;
    do_write(8'h4E, 3, 1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_open got=%b want=1", busy);
    end
    i2c_stop();
    repeat (4) @(posedge clk);
    exp_msg = 24'h574154;
    vectors++;
    if (ack_got.size() != 4 || ack_got.sum() with (int'(item)) != 4) begin
      miscompares++;
      $display("FAIL wat_acks got=%0d want=4",
               ack_got.sum() with (int'(item)));
    end
    vectors++;
    if (msg_data !== exp_msg || nval - v0 != 1 || nfe != f0) begin
      miscompares++;
      $display("FAIL wat_msg msg=%h val=%0d fe=%0d want=%h/1/0",
               msg_data, nval - v0, nfe - f0, exp_msg);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_close got=%b want=0", busy);
    end
  endtask

  task automatic test_wrong_addr();
    int v0, f0, o0;
    v0 = nval; f0 = nfe; o0 = noe;
    buf_b[0] = 8'h44; buf_b[1] = 8'h4F; buf_b[2] = 8'h4E;
    do_write(8'h50, 3, 1'b1);
    vectors++;
    if (noe != o0 || nval != v0 || nfe != f0 || msg_data !== exp_msg) begin
      miscompares++;
      $display("FAIL wrong_addr oe=%0d val=%0d fe=%0d msg=%h want=0/0/0/%h",
               noe - o0, nval - v0, nfe - f0, msg_data, exp_msg);
    end
  endtask

  task automatic test_short_long();
    int v0, f0;
    v0 = nval; f0 = nfe;
    buf_b[0] = 8'h44; buf_b[1] = 8'h4F;
    do_write(8'h4E, 2, 1'b1);
    vectors++;
    if (nfe - f0 != 1 || nval != v0 || msg_data !== exp_msg) begin
      miscompares++;
      $display("FAIL short_write fe=%0d val=%0d msg=%h want=1/0/%h",
               nfe - f0, nval - v0, msg_data, exp_msg);
    end
    v0 = nval; f0 = nfe;
    buf_b[0] = 8'h44; buf_b[1] = 8'h4F; buf_b[2] = 8'h4E; buf_b[3] = 8'h21;
    do_write(8'h4E, 4, 1'b1);
    vectors++;
    if (ack_got.size() != 5 || ack_got[3] !== 1'b1 || ack_got[4] !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_nack ack3=%b ack4=%b want=1/0",
               ack_got[3], ack_got[4]);
    end
    vectors++;
    if (nfe - f0 != 1 || nval != v0 || msg_data !== exp_msg) begin
      miscompares++;
      $display("FAIL overflow_stop fe=%0d val=%0d msg=%h want=1/0/%h",
               nfe - f0, nval - v0, msg_data, exp_msg);
    end
  endtask

  task automatic test_restart();
    int v0, f0;
    v0 = nval; f0 = nfe;
    buf_b[0] = 8'h49;
    do_write(8'h4E, 1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    buf_b[0] = 8'h49; buf_b[1] = 8'h44; buf_b[2] = 8'h4C;
    do_write(8'h4E, 3, 1'b1);
    exp_msg = 24'h49444c;
    vectors++;
    if (nfe - f0 != 1 || nval - v0 != 1 || msg_data !== exp_msg) begin
      miscompares++;
      $display("FAIL restart fe=%0d val=%0d msg=%h want=1/1/%h",
               nfe - f0, nval - v0, msg_data, exp_msg);
    end
  endtask

  task automatic test_read();
    bit a;
    logic [7:0] rb;
    logic [23:0] got;
    int v0, f0;
    v0 = nval; f0 = nfe;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h4F >> i));
    get_ack(a);
`ifdef LCD_I2C_TARGET_READBACK_EN
    vectors++;
    if (a !== 1'b1) begin
      miscompares++;
      $display("FAIL read_ack got=%b want=1", a);
    end
    got = '0;
    for (int i = 0; i < 3; i++) begin
      recv_byte(rb, i < 2);
      got = {got[15:0], rb};
    end
    vectors++;
    if (got !== exp_msg) begin
      miscompares++;
      $display("FAIL read_data got=%h want=%h", got, exp_msg);
    end
`else
    got = '0;
    rb = '0;
    vectors++;
    if (a !== 1'b0) begin
      miscompares++;
      $display("FAIL read_nack got=%b want=0", a);
    end
`endif
    i2c_stop();
    repeat (4) @(posedge clk);
    vectors++;
    if (nval != v0 || nfe != f0 || msg_data !== exp_msg) begin
      miscompares++;
      $display("FAIL read_side val=%0d fe=%0d msg=%h want=0/0/%h",
               nval - v0, nfe - f0, msg_data, exp_msg);
    end
  endtask

  task automatic test_random();
    int v0, f0, n, ev, ef;
    logic [7:0] ab;
    logic [6:0] ad;
    bit hit;
    for (int t = 0; t < 16; t++) begin
      v0 = nval; f0 = nfe;
      hit = 1'($urandom);
      if (hit) begin
        ab = 8'h4E;
      end else begin
        do ad = 7'($urandom); while (ad == 7'h27);
        ab = {ad, 1'($urandom)};
      end
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) buf_b[i] = 8'($urandom);
      do_write(ab, n, 1'b1);
      for (int i = 0; i <= n; i++) begin
        vectors++;
        if (ack_got[i] !== (hit && i <= 3)) begin
          miscompares++;
          $display("FAIL rnd_ack t=%0d byte=%0d got=%b want=%b",
                   t, i, ack_got[i], hit && i <= 3);
        end
      end
      ev = 0; ef = 0;
      if (hit && n == 3) begin
        exp_msg = {buf_b[0], buf_b[1], buf_b[2]};
        ev = 1;
      end else if (hit) begin
        ef = 1;
      end
      vectors++;
      if (nval - v0 != ev || nfe - f0 != ef || msg_data !== exp_msg) begin
        miscompares++;
        $display("FAIL rnd_end t=%0d val=%0d fe=%0d msg=%h want=%0d/%0d/%h",
                 t, nval - v0, nfe - f0, msg_data, ev, ef, exp_msg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_write_ok();
    test_wrong_addr();
    test_short_long();
    test_restart();
    test_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
